// File: rtl/regfile_writeback.sv
// Writeback arbiter for the register file write port: the ALU path and an in-order load queue
// share one port, and a pending-load scoreboard lets decode stall. Optional forwarding: REGFILE_WB_BYPASS_EN.
module regfile_writeback #(
  parameter int LQ_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  output logic [31:0] pending_o,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic        rs1_hit_o,
  output logic [31:0] rs1_fwd_o,
  output logic        rs2_hit_o,
  output logic [31:0] rs2_fwd_o,
`endif
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        rd_we_o
);

  localparam int PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_ent_t;

  wb_ent_t [LQ_DEPTH-1:0] q_mem;
  logic [PTR_W-1:0] wptr, rptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  wb_ent_t          head, win;
  logic             win_v;
  logic [31:0]      set_vec, clr_vec, pend_nxt;

  assign full        = (count == CNT_W'(LQ_DEPTH));
  assign empty       = (count == '0);
  assign lsu_ready_o = !full;
  assign alu_ready_o = !full;
  assign push        = lsu_valid_i && !full;
  assign head        = q_mem[rptr];

  // A full queue takes priority so the LSU can never be starved of return slots.
  always_comb begin
    win_v = 1'b0;
    pop   = 1'b0;
    win   = head;
    if (full) begin
      win_v = 1'b1;
      pop   = 1'b1;
    end else if (alu_valid_i) begin
      win_v = 1'b1;
      win   = '{rd: alu_rd_i, data: alu_data_i};
    end else if (!empty) begin
      win_v = 1'b1;
      pop   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) q_mem[wptr] <= '{rd: lsu_rd_i, data: lsu_data_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_we_o   <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
    end else if (win_v) begin
      rd_we_o   <= (win.rd != 5'd0);
      rd_addr_o <= win.rd;
      rd_data_o <= win.data;
    end else begin
      rd_we_o   <= 1'b0;
    end
  end

  // Set beats clear so a re-issue to the same register stays pending.
  always_comb begin
    set_vec     = (issue_valid_i && issue_rd_i != 5'd0) ? (32'd1 << issue_rd_i) : 32'd0;
    clr_vec     = pop ? (32'd1 << head.rd) : 32'd0;
    pend_nxt    = (pending_o & ~clr_vec) | set_vec;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending_o <= '0;
    else         pending_o <= pend_nxt;
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign rs1_hit_o = rd_we_o && (rd_addr_o == rs1_addr_i) && (rs1_addr_i != 5'd0);
  assign rs2_hit_o = rd_we_o && (rd_addr_o == rs2_addr_i) && (rs2_addr_i != 5'd0);
  assign rs1_fwd_o = rd_data_o;
  assign rs2_fwd_o = rd_data_o;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: ALU/load arbitration, queue backpressure,
// rd=0 handling, scoreboard set/clear and asynchronous reset.
module tb_regfile_writeback;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        lsu_valid = 1'b0;
  logic [4:0]  lsu_rd = '0;
  logic [31:0] lsu_data = '0;
  logic        lsu_ready;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] pending;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        rd_we;
`ifdef REGFILE_WB_BYPASS_EN
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_fwd, rs2_fwd;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_writeback #(.LQ_DEPTH(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data), .alu_ready_o(alu_ready),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data), .lsu_ready_o(lsu_ready),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .pending_o(pending),
`ifdef REGFILE_WB_BYPASS_EN
    .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_hit_o(rs1_hit), .rs1_fwd_o(rs1_fwd), .rs2_hit_o(rs2_hit), .rs2_fwd_o(rs2_fwd),
`endif
    .rd_addr_o(rd_addr), .rd_data_o(rd_data), .rd_we_o(rd_we)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, check readies, clock, check the registered write.
  task automatic cyc(input string tag,
                     input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic ear, input logic elr,
                     input logic ewe, input logic [4:0] eaddr, input logic [31:0] edata);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(ear));
    chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(elr));
    tick();
    chk({tag, ".we"},   32'(rd_we),   32'(ewe));
    chk({tag, ".addr"}, 32'(rd_addr), 32'(eaddr));
    chk({tag, ".data"}, rd_data,      edata);
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_rd = rd;
    tick();
    issue_valid = 1'b0; issue_rd = '0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst.we", 32'(rd_we), 32'd0);
    chk("rst.addr", 32'(rd_addr), 32'd0);
    chk("rst.data", rd_data, 32'd0);
    chk("rst.pending", pending, 32'd0);
    chk("rst.lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rst.alu_ready", 32'(alu_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // ALU single-cycle write, then hold on idle
    cyc("alu5", 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 1, 1, 5, 32'hDEADBEEF);
    cyc("idle", 0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 32'hDEADBEEF);

    // Load to x7: pending set, two-cycle writeback, pending falls with we
    issue(7);
    chk("ld7.pend_set", pending, 32'h0000_0080);
    cyc("ld7.push", 0, 0, 0, 1, 7, 32'h12345678, 1, 1, 0, 5, 32'hDEADBEEF);
    chk("ld7.pend_hold", pending, 32'h0000_0080);
    cyc("ld7.wb", 0, 0, 0, 0, 0, 0, 1, 1, 1, 7, 32'h12345678);
    chk("ld7.pend_clr", pending, 32'd0);

    // ALU every cycle, 3 back-to-back loads, depth 2
    cyc("bp0", 1, 10, 32'hA0, 1, 20, 32'h100, 1, 1, 1, 10, 32'hA0);
    cyc("bp1", 1, 11, 32'hA1, 1, 21, 32'h101, 1, 1, 1, 11, 32'hA1);
    cyc("bp2", 1, 12, 32'hA2, 1, 22, 32'h102, 0, 0, 1, 20, 32'h100);
    cyc("bp3", 1, 12, 32'hA2, 1, 22, 32'h102, 1, 1, 1, 12, 32'hA2);
    cyc("bp4", 1, 13, 32'hA3, 0, 0, 0, 0, 0, 1, 21, 32'h101);
    cyc("bp5", 1, 13, 32'hA3, 0, 0, 0, 1, 1, 1, 13, 32'hA3);
    cyc("bp6", 0, 0, 0, 0, 0, 0, 1, 1, 1, 22, 32'h102);
    cyc("bp7", 0, 0, 0, 0, 0, 0, 1, 1, 0, 22, 32'h102);

    // rd = 0 consumed without writing; address/data still update
    cyc("z.alu", 1, 0, 32'h55, 0, 0, 0, 1, 1, 0, 0, 32'h55);
    cyc("z.push", 0, 0, 0, 1, 0, 32'h66, 1, 1, 0, 0, 32'h55);
    cyc("z.ld", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h66);
    issue(0);
    chk("z.pend", pending, 32'd0);

    // Re-issue to x3 on the pop edge: set wins
    issue(3);
    chk("x3.pend_set", pending, 32'h0000_0008);
    cyc("x3.push", 0, 0, 0, 1, 3, 32'h33, 1, 1, 0, 0, 32'h66);
    issue_valid = 1'b1; issue_rd = 5'd3;
    cyc("x3.pop", 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 32'h33);
    issue_valid = 1'b0; issue_rd = '0;
    chk("x3.pend_keep", pending, 32'h0000_0008);
    cyc("x3.push2", 0, 0, 0, 1, 3, 32'h34, 1, 1, 0, 3, 32'h33);
    cyc("x3.pop2", 0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 32'h34);
    chk("x3.pend_clr", pending, 32'd0);

`ifdef REGFILE_WB_BYPASS_EN
    rs1_addr = 5'd0; rs2_addr = 5'd9;
    cyc("byp", 1, 9, 32'hA5A5A5A5, 0, 0, 0, 1, 1, 1, 9, 32'hA5A5A5A5);
    chk("byp.rs2_hit", 32'(rs2_hit), 32'd1);
    chk("byp.rs2_fwd", rs2_fwd, 32'hA5A5A5A5);
    chk("byp.rs1_hit", 32'(rs1_hit), 32'd0);
    alu_valid = 1'b0;
`endif

    // Reset with two queued loads
    issue(4);
    issue(6);
    chk("rq.pend", pending, 32'h0000_0050);
    cyc("rq0", 1, 1, 32'h11, 1, 4, 32'h44, 1, 1, 1, 1, 32'h11);
    cyc("rq1", 1, 2, 32'h22, 1, 6, 32'h66, 1, 1, 1, 2, 32'h22);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rq.async_we", 32'(rd_we), 32'd0);
    chk("rq.pend", pending, 32'd0);
    chk("rq.lsu_ready", 32'(lsu_ready), 32'd1);
    chk("rq.alu_ready", 32'(alu_ready), 32'd1);
    chk("rq.addr", 32'(rd_addr), 32'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("rq.no_wr0", 32'(rd_we), 32'd0);
    tick();
    chk("rq.no_wr1", 32'(rd_we), 32'd0);
    chk("rq.pend_after", pending, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
